// File: rtl/sched_event_dispatcher.sv
// ----------------------------------------------------------------------------
// sched_event_dispatcher
//
// Purpose:
//   This block sits at the consumer end of the spike scheduler FIFO. It pops
//   one event at a time, decodes it and turns it into valid/ready dispatch
//   beats for the neuron/synapse update pipeline:
//     - spike (00) and time reference (10) events fan out into N beats,
//       one for each post-synaptic neuron index 0..N-1
//     - virtual events (01) produce a single beat addressed to addr[NW-1:0]
//     - reserved events (11) are popped and silently discarded
//
// Optional feature:
//   EVT_COUNT_EN - when defined, saturating 16-bit counters of accepted spike
//                  and time-reference events are kept. When undefined, the
//                  counter outputs are tied to 0.
//
// Ports:
//   CLK               system clock
//   RST               synchronous active-high reset
//   CTRL_ENABLE       permits popping new events (an event in progress always
//                     completes)
//   SCHED_EMPTY       scheduler FIFO empty
//   SCHED_DATA_OUT    show-ahead head entry {virts[1:0], addr[M-1:0]}
//   CTRL_SCHED_POP_N  active-low pop; the head is consumed while it is low
//   DISP_VALID        dispatch beat valid
//   DISP_READY        downstream accepts the beat
//   DISP_TYPE         00 spike, 01 virtual, 10 time reference
//   DISP_PRE_ADDR     latched event address (0 for time reference)
//   DISP_POST_ADDR    post-neuron index of the current beat
//   DISP_LAST         final beat of the current event
//   BUSY              high whenever the FSM is not in IDLE
//   EVT_CNT_SPIKE     accepted spike events
//   EVT_CNT_TREF      accepted time-reference events
// ----------------------------------------------------------------------------
module sched_event_dispatcher #(
    parameter int N  = 256,
    parameter int M  = 10,
    parameter int NW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CTRL_ENABLE,
    input  logic          SCHED_EMPTY,
    input  logic [M+1:0]  SCHED_DATA_OUT,
    output logic          CTRL_SCHED_POP_N,
    output logic          DISP_VALID,
    input  logic          DISP_READY,
    output logic [1:0]    DISP_TYPE,
    output logic [M-1:0]  DISP_PRE_ADDR,
    output logic [NW-1:0] DISP_POST_ADDR,
    output logic          DISP_LAST,
    output logic          BUSY,
    output logic [15:0]   EVT_CNT_SPIKE,
    output logic [15:0]   EVT_CNT_TREF
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_SWEEP = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [1:0]    LP_SPIKE = 2'b00;
    localparam logic [1:0]    LP_VIRT  = 2'b01;
    localparam logic [1:0]    LP_TREF  = 2'b10;
    localparam logic [1:0]    LP_RSVD  = 2'b11;
    // Index of the beat just before the final one; when that beat is
    // accepted the next index is N-1 and LAST must be raised.
    localparam logic [NW-1:0] LP_POST_PEN = NW'(N - 2);

    state_t        r_state;
    logic [1:0]    r_virts;
    logic [M-1:0]  r_addr;
    logic          r_valid;
    logic          r_last;
    logic          r_busy;
    logic [1:0]    r_type;
    logic [M-1:0]  r_pre;
    logic [NW-1:0] r_post;

    logic          w_pop;
    logic          w_accept;

    // The pop is combinational so the head is consumed in the IDLE cycle
    // itself. RST is included so no entry is consumed while in reset.
    assign w_pop    = (r_state == S_IDLE) && CTRL_ENABLE && !SCHED_EMPTY && !RST;
    assign w_accept = r_valid && DISP_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_virts <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_type  <= '0;
            r_pre   <= '0;
            r_post  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_virts <= SCHED_DATA_OUT[M+1:M];
                        r_addr  <= SCHED_DATA_OUT[M-1:0];
                        r_busy  <= 1'b1;
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    if (r_virts == LP_RSVD) begin
                        r_state <= S_DROP;
                    end else begin
                        r_state <= S_SWEEP;
                        r_valid <= 1'b1;
                        r_type  <= r_virts;
                        r_pre   <= (r_virts == LP_TREF) ? '0 : r_addr;
                        if (r_virts == LP_VIRT) begin
                            r_post <= r_addr[NW-1:0];
                            r_last <= 1'b1;
                        end else begin
                            r_post <= '0;
                            r_last <= 1'b0;
                        end
                    end
                end
                S_SWEEP: begin
                    // Everything holds while the beat is not accepted.
                    if (w_accept) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_post <= r_post + 1'b1;
                            r_last <= (r_post == LP_POST_PEN);
                        end
                    end
                end
                S_DROP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CTRL_SCHED_POP_N = ~w_pop;
    assign DISP_VALID       = r_valid;
    assign DISP_TYPE        = r_type;
    assign DISP_PRE_ADDR    = r_pre;
    assign DISP_POST_ADDR   = r_post;
    assign DISP_LAST        = r_last;
    assign BUSY             = r_busy;

`ifdef EVT_COUNT_EN
    logic [15:0] r_cnt_spike;
    logic [15:0] r_cnt_tref;

    // Counted once per event in POP; both counters saturate at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_spike <= '0;
            r_cnt_tref  <= '0;
        end else if (r_state == S_POP) begin
            if (r_virts == LP_SPIKE && r_cnt_spike != 16'hFFFF)
                r_cnt_spike <= r_cnt_spike + 16'd1;
            if (r_virts == LP_TREF && r_cnt_tref != 16'hFFFF)
                r_cnt_tref <= r_cnt_tref + 16'd1;
        end
    end

    assign EVT_CNT_SPIKE = r_cnt_spike;
    assign EVT_CNT_TREF  = r_cnt_tref;
`else
    assign EVT_CNT_SPIKE = 16'd0;
    assign EVT_CNT_TREF  = 16'd0;
`endif

endmodule
